uart_flag_bank: RTL and testbench

Parametrised bank of N set/reset status flags for the UART status path, such as TX-ready, RX-ready and framing flags. Each flag is a clocked SR bit with a per-bit reset value and a selectable set/clear priority. The bank adds three things a bare SR bit lacks:
- host write-1-to-clear;
- sticky overrun capture;
- rising-edge pending bits with a maskable, registered interrupt.

It sits between UART datapath event strobes and the host register interface.

---
 rtl/uart_flag_bank.sv | 75 +++++++
 tb/tb_uart_flag_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_flag_bank.sv
// Bank of N clocked SR status flags with host write-1-to-clear, sticky overrun
// capture, rising-edge pending bits and a maskable registered interrupt.
module uart_flag_bank #(
    parameter int          N            = 8,
    parameter logic [N-1:0] RESET_VAL   = {N{1'b1}},
    parameter bit          SET_PRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] set,
    input  logic [N-1:0] clr,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [N-1:0] wr_data,
    output logic [N-1:0] flags,
    output logic [N-1:0] ovf,
    output logic [N-1:0] pend,
    output logic [N-1:0] mask,
    output logic         irq
);

    logic [N-1:0] r_flags;
    logic [N-1:0] r_ovf;
    logic [N-1:0] r_pend;
    logic [N-1:0] r_mask;
    logic         r_irq;

    logic [N-1:0] w_hclr;
    logic [N-1:0] w_kill;
    logic [N-1:0] w_flags_nxt;
    logic [N-1:0] w_ovf_nxt;
    logic [N-1:0] w_pend_nxt;

    assign w_hclr = {N{wr_en & ~wr_sel}} & wr_data;
    assign w_kill = clr | w_hclr;

    generate
        if (SET_PRIORITY) begin : g_set_wins
            assign w_flags_nxt = set | (r_flags & ~w_kill);
        end else begin : g_clr_wins
            assign w_flags_nxt = (r_flags | set) & ~w_kill;
        end
    endgenerate

    // New events are ORed in after the host clear so a same-cycle event survives.
    assign w_ovf_nxt  = (r_ovf  & ~w_hclr) | (set & r_flags);
    assign w_pend_nxt = (r_pend & ~w_hclr) | (~r_flags & w_flags_nxt);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= RESET_VAL;
            r_ovf   <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            r_ovf   <= w_ovf_nxt;
            r_pend  <= w_pend_nxt;
            if (wr_en && wr_sel) begin
                r_mask <= wr_data;
            end
            r_irq   <= |(r_pend & r_mask);
        end
    end

    assign flags = r_flags;
    assign ovf   = r_ovf;
    assign pend  = r_pend;
    assign mask  = r_mask;
    assign irq   = r_irq;

endmodule

// File: tb/tb_uart_flag_bank.sv
// Directed self-checking bench for uart_flag_bank: a set-priority instance and
// a clear-priority instance share one stimulus stream.
module tb_uart_flag_bank;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic         wr_en;
    logic         wr_sel;
    logic [N-1:0] wr_data;

    logic [N-1:0] flags1, ovf1, pend1, mask1;
    logic         irq1;
    logic [N-1:0] flags0, ovf0, pend0, mask0;
    logic         irq0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    uart_flag_bank #(.N(N), .RESET_VAL(8'hA5), .SET_PRIORITY(1'b1)) dut_sp1 (
        .clk(clk), .reset(reset), .set(set), .clr(clr),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .flags(flags1), .ovf(ovf1), .pend(pend1), .mask(mask1), .irq(irq1)
    );

    uart_flag_bank #(.N(N), .RESET_VAL(8'hA5), .SET_PRIORITY(1'b0)) dut_sp0 (
        .clk(clk), .reset(reset), .set(set), .clr(clr),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .flags(flags0), .ovf(ovf0), .pend(pend0), .mask(mask0), .irq(irq0)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: got %02h, expected %02h", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle so inputs and samples sit away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set = '0; clr = '0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
    endtask

    task automatic w1c(input logic [7:0] d);
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = d;
    endtask

    task automatic wmask(input logic [7:0] d);
        wr_en = 1'b1; wr_sel = 1'b1; wr_data = d;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        check("rst_flags",  flags1, 8'hA5);
        check("rst_ovf",    ovf1,   8'h00);
        check("rst_pend",   pend1,  8'h00);
        check("rst_mask",   mask1,  8'h00);
        check("rst_irq",    {7'b0, irq1}, 8'h00);
        check("rst_flags0", flags0, 8'hA5);
        reset = 1'b0;

        // Clear all flags; falling edges must not create pend bits.
        w1c(8'hFF); step(); idle();
        check("clr_all_flags", flags1, 8'h00);
        check("clr_all_pend",  pend1,  8'h00);

        // Edge and interrupt latency.
        wmask(8'h01); step(); idle();
        check("mask01", mask1, 8'h01);
        set = 8'h01; step(); idle();
        check("lat_flags", flags1, 8'h01);
        check("lat_pend",  pend1,  8'h01);
        check("lat_irq_k", {7'b0, irq1}, 8'h00);
        step();
        check("lat_irq_k1", {7'b0, irq1}, 8'h01);
        w1c(8'h01); step(); idle();
        check("w1c_flags", flags1, 8'h00);
        check("w1c_pend",  pend1,  8'h00);
        check("w1c_irq_k", {7'b0, irq1}, 8'h01);
        step();
        check("w1c_irq_k1", {7'b0, irq1}, 8'h00);

        // Overrun.
        set = 8'h08; step(); idle();
        check("ovr_first", ovf1, 8'h00);
        step();
        set = 8'h08; step(); idle();
        check("ovr_second", ovf1, 8'h08);
        check("ovr_pend",   pend1, 8'h08);
        clr = 8'h08; step(); idle();
        check("ovr_clr_flags", flags1, 8'h00);
        check("ovr_clr_keeps", ovf1,   8'h08);
        w1c(8'h08); step(); idle();
        check("ovr_w1c", ovf1,  8'h00);
        check("ovr_w1c_pend", pend1, 8'h00);

        // Priority.
        set = 8'h04; clr = 8'h04; step(); idle();
        check("prio_sp1", flags1, 8'h04);
        check("prio_sp0", flags0, 8'h00);
        check("prio_pend_sp1", pend1, 8'h04);
        check("prio_pend_sp0", pend0, 8'h00);
        clr = 8'h04; w1c(8'h04); step(); idle();
        check("prio_cleanup", flags1 | pend1, 8'h00);

        // Simultaneous W1C and event.
        set = 8'h20; step(); idle();
        clr = 8'h20; step(); idle();
        check("sim_pre_flags", flags1, 8'h00);
        check("sim_pre_pend",  pend1,  8'h20);
        w1c(8'h20); set = 8'h20; step(); idle();
        check("sim_flags_sp1", flags1, 8'h20);
        check("sim_pend_sp1",  pend1,  8'h20);
        check("sim_ovf_sp1",   ovf1,   8'h00);
        check("sim_flags_sp0", flags0, 8'h00);
        check("sim_pend_sp0",  pend0,  8'h00);
        w1c(8'hFF); step(); idle();

        // Mask gating and mid-operation reset.
        wmask(8'h00); step(); idle();
        set = 8'hFF; step(); idle();
        check("all_flags", flags1, 8'hFF);
        check("all_pend",  pend1,  8'hFF);
        check("all_ovf",   ovf1,   8'h00);
        step();
        check("masked_irq", {7'b0, irq1}, 8'h00);
        wmask(8'h80); step(); idle();
        check("mask80",      mask1, 8'h80);
        check("mask80_pend", pend1, 8'hFF);
        check("mask_irq_k",  {7'b0, irq1}, 8'h00);
        step();
        check("mask_irq_k1", {7'b0, irq1}, 8'h01);
        reset = 1'b1; set = 8'hFF; wmask(8'hFF); step(); idle();
        check("mid_rst_flags", flags1, 8'hA5);
        check("mid_rst_ovf",   ovf1,   8'h00);
        check("mid_rst_pend",  pend1,  8'h00);
        check("mid_rst_mask",  mask1,  8'h00);
        check("mid_rst_irq",   {7'b0, irq1}, 8'h00);
        check("mid_rst_flags0", flags0, 8'hA5);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
